// File: rtl/safe_mode_sequencer.sv
// safe_mode_sequencer: lockstep mode/master config block that halts, syncs, then commits changes
module safe_mode_sequencer #(
  parameter int NCores = 3,
  parameter int CoreIdW = $clog2(NCores),
  parameter int TimeoutW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_req_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  output logic [31:0]         cfg_rdata_o,
  input  logic [NCores-1:0]   core_halted_i,
  input  logic                sync_done_i,
  input  logic                en_ext_debug_i,
  output logic [1:0]          mode_o,
  output logic                safe_mode_o,
  output logic [CoreIdW-1:0]  master_core_o,
  output logic                critical_section_o,
  output logic [NCores-1:0]   debug_req_o,
  output logic                initial_sync_o,
  output logic                busy_o,
  output logic                irq_o
);
  typedef enum logic [2:0] {IDLE, HALT, SYNC, APPLY, ERR} state_t;
  state_t state;
  logic [1:0] pend_mode;
  logic [CoreIdW-1:0] pend_master, w_master;
  logic [TimeoutW-1:0] timeout_q, cnt;
  logic st_req, st_ext, ext_prev;
  logic wr, wr_ctrl, ctrl_ok, tmo, unused;
  logic [2:0] clr;
  assign w_master = cfg_wdata_i[2+:CoreIdW];
  assign wr = cfg_req_i && cfg_we_i;
  assign wr_ctrl = wr && cfg_addr_i == 2'd0;
  assign clr = (wr && cfg_addr_i == 2'd1) ? cfg_wdata_i[3:1] : 3'b000;
  assign ctrl_ok = state == IDLE && !critical_section_o && cfg_wdata_i[1:0] != 2'd3
                   && int'(w_master) < NCores && (cfg_wdata_i[1:0] != 2'd2 || NCores >= 3);
  assign tmo = timeout_q != '0 && cnt == timeout_q;
  assign safe_mode_o = mode_o != 2'd0;
  assign unused = ^cfg_wdata_i;
  always_comb begin
    cfg_rdata_o = cfg_addr_i == 2'd0 ? 32'({master_core_o, mode_o})
                : cfg_addr_i == 2'd1 ? 32'({st_ext, st_req, irq_o, busy_o})
                : cfg_addr_i == 2'd2 ? 32'(critical_section_o)
                : 32'(timeout_q);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      mode_o <= '0;
      master_core_o <= '0;
      pend_mode <= '0;
      pend_master <= '0;
      critical_section_o <= 1'b0;
      debug_req_o <= '0;
      initial_sync_o <= 1'b0;
      busy_o <= 1'b0;
      timeout_q <= '1;
      cnt <= '0;
      irq_o <= 1'b0;
      st_req <= 1'b0;
      st_ext <= 1'b0;
      ext_prev <= 1'b0;
    end else begin
      ext_prev <= en_ext_debug_i;
      irq_o <= (irq_o && !clr[0]) || state == ERR;
      st_req <= (st_req && !clr[1]) || (wr_ctrl && !ctrl_ok);
      st_ext <= (st_ext && !clr[2]) || (en_ext_debug_i && !ext_prev);
      if (wr && cfg_addr_i == 2'd2) critical_section_o <= cfg_wdata_i[0];
      if (wr && cfg_addr_i == 2'd3) timeout_q <= cfg_wdata_i[TimeoutW-1:0];
      case (state)
        IDLE: if (wr_ctrl && ctrl_ok) begin
          pend_mode <= cfg_wdata_i[1:0];
          pend_master <= w_master;
          cnt <= '0;
          debug_req_o <= '1;
          busy_o <= 1'b1;
          state <= HALT;
        end
        HALT: if (&core_halted_i) begin
          cnt <= '0;
          initial_sync_o <= 1'b1;
          state <= SYNC;
        end else if (tmo) begin
          debug_req_o <= '0;
          state <= ERR;
        end else cnt <= cnt + 1'b1;
        SYNC: if (sync_done_i || tmo) begin
          debug_req_o <= '0;
          initial_sync_o <= 1'b0;
          state <= sync_done_i ? APPLY : ERR;
        end else cnt <= cnt + 1'b1;
        APPLY: begin
          mode_o <= pend_mode;
          master_core_o <= pend_master;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/safe_mode_sequencer.md
Name: safe_mode_sequencer

Overview:
- Parametrised successor of the safe-wrapper control register block for an NCores-wide lockstep cluster.
- Holds the operating mode (independent / DMR / TMR), master core and critical-section flag.
- Unlike a plain register block, it never applies a mode or master change directly. A sequencer halts all cores via debug request, runs the initial-sync handshake, then commits the new configuration, with a timeout and sticky error reporting.
- Sits between the system configuration bus and the safe wrapper's core-control inputs.

Parameters:
- NCores, 3, number of cores in the cluster (2..8).
- CoreIdW, $clog2(NCores), width of the master-core index.
- TimeoutW, 16, width of the timeout counter and TIMEOUT register.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- cfg_req_i  in  1  bus access valid; single-cycle, always accepted
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_addr_i  in  2  word index: 0 CTRL, 1 STATUS, 2 CRIT, 3 TIMEOUT
- cfg_wdata_i  in  32  write data
- cfg_rdata_o  out  32  read data, combinational, valid in the cycle of the read request
- core_halted_i  in  NCores  per-core "in debug mode" status
- sync_done_i  in  1  master reports initial sync complete
- en_ext_debug_i  in  1  external debug enable level
- mode_o  out  2  applied mode: 0 indep, 1 DMR, 2 TMR
- safe_mode_o  out  1  mode_o != 0
- master_core_o  out  CoreIdW  applied master index
- critical_section_o  out  1  CRIT[0]
- debug_req_o  out  NCores  halt request to cores
- initial_sync_o  out  1  sync request to master
- busy_o  out  1  FSM not in IDLE
- irq_o  out  1  level: STATUS.timeout_err

Behaviour:
- Reset values:
  - mode_o=0, master_core_o=0, critical_section_o=0, debug_req_o=0, initial_sync_o=0, busy_o=0.
  - TIMEOUT=16'hFFFF; all STATUS bits 0; FSM in IDLE.
- Reset asserted mid-sequence aborts immediately to these values.
- Register map:
  - CTRL: bits [1:0] mode, bits [2+CoreIdW-1:2] master. Reads return the applied values, not the pending ones.
  - STATUS:
    - bit0 busy (read-only)
    - bit1 timeout_err, W1C
    - bit2 req_err, W1C
    - bit3 ext_dbg_seen, W1C
  - CRIT: bit0, R/W, takes effect the next cycle.
  - TIMEOUT: [TimeoutW-1:0], R/W; 0 disables the timeout.
  - Unused bits read 0.
- CTRL write acceptance: a write starts a sequence only if all of the following hold:
  - FSM is in IDLE;
  - critical_section_o=0;
  - mode != 3;
  - master < NCores;
  - mode=1 requires NCores>=2 and mode=2 requires NCores>=3.
- Otherwise the write is dropped, req_err is set, and applied state is unchanged.
- On acceptance, pending mode and master are latched and the FSM enters HALT on the next cycle.
- FSM:
  - IDLE → HALT on an accepted CTRL write.
  - HALT:
    - debug_req_o all ones; cycle counter increments from 0.
    - &core_halted_i → SYNC, counter cleared.
    - counter == TIMEOUT (TIMEOUT != 0) → ERR.
    - If halted and timeout occur in the same cycle, halted wins.
  - SYNC:
    - debug_req_o held all ones; initial_sync_o=1.
    - sync_done_i → APPLY.
    - Timeout counted and resolved as in HALT.
  - APPLY (one cycle):
    - mode_o and master_core_o take the pending values, visible from the next cycle.
    - debug_req_o=0, initial_sync_o=0 → IDLE.
  - ERR (one cycle):
    - timeout_err set; debug_req_o=0, initial_sync_o=0; applied state unchanged → IDLE.
- busy_o=1 in HALT, SYNC, APPLY and ERR.
- A minimal sequence takes 3 cycles after the write (HALT, SYNC, APPLY) when core_halted_i and sync_done_i are already high.
- CRIT writes are accepted while busy; they do not abort an in-flight sequence.
- ext_dbg_seen is set on a rising edge of en_ext_debug_i (registered previous value; previous value resets to 0).
- STATUS bit clearing: when a W1C clear and a hardware set hit the same bit in the same cycle, the set wins.
- A CTRL write and a STATUS read in the same cycle are impossible (single port). A read always reflects pre-write state.

Test Plan:
- Reset, then read all registers → CTRL=0, STATUS=0, CRIT=0, TIMEOUT=0xFFFF; all outputs 0.
- NCores=3: write CTRL mode=2, master=1; raise core_halted_i=3'b111 after 5 cycles and sync_done_i 4 cycles later → debug_req_o=3'b111 throughout HALT/SYNC; initial_sync_o high only in SYNC; mode_o=2, master_core_o=1, safe_mode_o=1 after APPLY; busy_o low.
- TIMEOUT=10; write CTRL mode=1 with core_halted_i=3'b011 held → ERR after 10 counted HALT cycles; irq_o=1; mode_o unchanged (0); debug_req_o=0. Writing STATUS=0x2 clears irq_o.
- Illegal requests each set req_err with no FSM start:
  - CTRL mode=3;
  - master=3 with NCores=3;
  - any CTRL write while CRIT=1;
  - a second CTRL write during HALT.
- Toggle en_ext_debug_i 0→1→0→1 → ext_dbg_seen=1. W1C in the same cycle as a new rising edge → bit stays 1.
- Assert rst_i during SYNC → debug_req_o=0, initial_sync_o=0, busy_o=0 the next cycle; mode_o holds the reset value 0.
